// File: rtl/dpram_sc_be_clr_pkg.sv
// dpram_sc_be_clr_pkg: shared definitions for the single-clock dual-port RAM.
//   clr_state_e     - clear engine states (ST_CLEAR / ST_RUN)
//   RDW_WRITE_FIRST - same-port read-during-write returns the merged new word
//   RDW_READ_FIRST  - same-port read-during-write returns the old word
//   bit_fit(n)      - address width needed to index n words (minimum 1)
// Optional feature macro: DPRAM_SC_PARITY_EN (not referenced here).
package dpram_sc_be_clr_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } clr_state_e;

  localparam int unsigned RDW_WRITE_FIRST = 0;
  localparam int unsigned RDW_READ_FIRST  = 1;

  function automatic int unsigned bit_fit(input int unsigned n);
    int unsigned w;
    w = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/dpram_sc_rd_pipe.sv
// dpram_sc_rd_pipe: per-port read output stage.
//   clk, rst         - clock, synchronous active-high reset (flushes all stages)
//   in_valid/in_data - accepted read and its word, presented combinationally
//   in_perr          - parity error of that word (DPRAM_SC_PARITY_EN only)
//   rdata/rvalid     - read result after 1 (OREG=0) or 2 (OREG=1) cycles;
//                      rdata holds its last value while rvalid is low
//   perr             - parity error aligned with rvalid (DPRAM_SC_PARITY_EN only)
// Optional feature macro: DPRAM_SC_PARITY_EN.
module dpram_sc_rd_pipe #(
  parameter int unsigned DBW  = 32,
  parameter int unsigned OREG = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  input  logic [DBW-1:0] in_data,
`ifdef DPRAM_SC_PARITY_EN
  input  logic           in_perr,
  output logic           perr,
`endif
  output logic [DBW-1:0] rdata,
  output logic           rvalid
);

  logic           s1_valid;
  logic [DBW-1:0] s1_data;
`ifdef DPRAM_SC_PARITY_EN
  logic           s1_perr;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
`ifdef DPRAM_SC_PARITY_EN
      s1_perr  <= 1'b0;
`endif
    end else begin
      s1_valid <= in_valid;
      if (in_valid) s1_data <= in_data;
`ifdef DPRAM_SC_PARITY_EN
      s1_perr  <= in_valid & in_perr;
`endif
    end
  end

  if (OREG != 0) begin : g_oreg
    logic           s2_valid;
    logic [DBW-1:0] s2_data;
`ifdef DPRAM_SC_PARITY_EN
    logic           s2_perr;
`endif
    always_ff @(posedge clk) begin
      if (rst) begin
        s2_valid <= 1'b0;
        s2_data  <= '0;
`ifdef DPRAM_SC_PARITY_EN
        s2_perr  <= 1'b0;
`endif
      end else begin
        s2_valid <= s1_valid;
        if (s1_valid) s2_data <= s1_data;
`ifdef DPRAM_SC_PARITY_EN
        s2_perr  <= s1_perr;
`endif
      end
    end
    assign rdata  = s2_data;
    assign rvalid = s2_valid;
`ifdef DPRAM_SC_PARITY_EN
    assign perr   = s2_perr;
`endif
  end else begin : g_direct
    assign rdata  = s1_data;
    assign rvalid = s1_valid;
`ifdef DPRAM_SC_PARITY_EN
    assign perr   = s1_perr;
`endif
  end

endmodule

// File: rtl/dpram_sc_be_clr.sv
// dpram_sc_be_clr: single-clock true dual-port RAM with byte enables,
// read strobes/valid, selectable read-during-write, collision flag and a
// clear engine that zeroes the array after reset or on iCLR.
//   iCLK, iRST            - clock, synchronous active-high reset
//   iCLR                  - pulse: clear the whole array (ignored while clearing)
//   oREADY                - clear engine idle, ports serviced
//   iPx_ADDR/RD/WR/BE/WDATA - port A/B request (x = A, B)
//   oPx_RDATA/oPx_RVALID  - port A/B read result
//   oCOLL                 - both ports wrote overlapping lanes of one address
//   oPx_PERR              - read parity error (DPRAM_SC_PARITY_EN only)
// Optional feature macro: DPRAM_SC_PARITY_EN (one even-parity bit per lane).
module dpram_sc_be_clr
  import dpram_sc_be_clr_pkg::*;
#(
  parameter  int unsigned DBW      = 32,
  parameter  int unsigned DEPTH    = 1023,
  parameter  int unsigned BEW      = 8,
  parameter  int unsigned OREG     = 0,
  parameter  int unsigned RDW_MODE = 0,
  localparam int unsigned NBE      = DBW / BEW,
  localparam int unsigned ABW      = bit_fit(DEPTH)
) (
  input  logic           iCLK,
  input  logic           iRST,
  input  logic           iCLR,
  output logic           oREADY,
  input  logic [ABW-1:0] iPA_ADDR,
  input  logic           iPA_RD,
  input  logic           iPA_WR,
  input  logic [NBE-1:0] iPA_BE,
  input  logic [DBW-1:0] iPA_WDATA,
  output logic [DBW-1:0] oPA_RDATA,
  output logic           oPA_RVALID,
  input  logic [ABW-1:0] iPB_ADDR,
  input  logic           iPB_RD,
  input  logic           iPB_WR,
  input  logic [NBE-1:0] iPB_BE,
  input  logic [DBW-1:0] iPB_WDATA,
  output logic [DBW-1:0] oPB_RDATA,
  output logic           oPB_RVALID,
`ifdef DPRAM_SC_PARITY_EN
  output logic           oPA_PERR,
  output logic           oPB_PERR,
`endif
  output logic           oCOLL
);

  localparam logic [ABW:0]   DEPTH_W = (ABW + 1)'(DEPTH);
  localparam logic [ABW-1:0] LAST    = ABW'(DEPTH - 1);
  localparam bit             WF      = (RDW_MODE == RDW_WRITE_FIRST);

  logic [DBW-1:0] mem [DEPTH];
`ifdef DPRAM_SC_PARITY_EN
  logic [NBE-1:0] par [DEPTH];
`endif

  clr_state_e     state, state_nx;
  logic [ABW-1:0] cnt;
  logic           run, a_in, b_in, a_rd, b_rd, a_wr, b_wr;
  logic [DBW-1:0] a_old, b_old, a_rword, b_rword;

  function automatic logic [DBW-1:0] merge_lanes(input logic [DBW-1:0] old_w,
                                                 input logic [DBW-1:0] new_w,
                                                 input logic [NBE-1:0] be);
    logic [DBW-1:0] w;
    w = old_w;
    for (int unsigned k = 0; k < NBE; k++)
      if (be[k]) w[k*BEW +: BEW] = new_w[k*BEW +: BEW];
    return w;
  endfunction

  // ---------------- clear engine ----------------
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state <= ST_CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (state == ST_CLEAR && cnt != LAST) cnt <= cnt + 1'b1;
      else                                  cnt <= '0;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_CLEAR: if (cnt == LAST) state_nx = ST_RUN;
      ST_RUN:   if (iCLR)        state_nx = ST_CLEAR;
      default:                   state_nx = ST_CLEAR;
    endcase
  end

  assign run    = (state == ST_RUN) && !iRST;
  assign oREADY = (state == ST_RUN);

  // ---------------- request qualification ----------------
  assign a_in = ({1'b0, iPA_ADDR} < DEPTH_W);
  assign b_in = ({1'b0, iPB_ADDR} < DEPTH_W);
  assign a_rd = run & iPA_RD;
  assign b_rd = run & iPB_RD;
  assign a_wr = run & iPA_WR & a_in;
  assign b_wr = run & iPB_WR & b_in;

  // Reads see the array before this cycle's writes; write-first only merges
  // the reading port's own write, so cross-port reads stay pre-write.
  always_comb begin
    a_old   = a_in ? mem[iPA_ADDR] : '0;
    b_old   = b_in ? mem[iPB_ADDR] : '0;
    a_rword = (WF && a_wr) ? merge_lanes(a_old, iPA_WDATA, iPA_BE) : a_old;
    b_rword = (WF && b_wr) ? merge_lanes(b_old, iPB_WDATA, iPB_BE) : b_old;
  end

`ifdef DPRAM_SC_PARITY_EN
  function automatic logic [NBE-1:0] lane_parity(input logic [DBW-1:0] w);
    logic [NBE-1:0] p;
    for (int unsigned k = 0; k < NBE; k++) p[k] = ^w[k*BEW +: BEW];
    return p;
  endfunction

  logic [NBE-1:0] a_pold, b_pold, a_rpar, b_rpar;
  logic           a_perr, b_perr;

  always_comb begin
    a_pold = a_in ? par[iPA_ADDR] : '0;
    b_pold = b_in ? par[iPB_ADDR] : '0;
    a_rpar = (WF && a_wr) ? ((iPA_BE & lane_parity(iPA_WDATA)) | (~iPA_BE & a_pold)) : a_pold;
    b_rpar = (WF && b_wr) ? ((iPB_BE & lane_parity(iPB_WDATA)) | (~iPB_BE & b_pold)) : b_pold;
    a_perr = |(lane_parity(a_rword) ^ a_rpar);
    b_perr = |(lane_parity(b_rword) ^ b_rpar);
  end
`endif

  // ---------------- array write ----------------
  // Port B is applied first so port A wins on overlapping lanes.
  always_ff @(posedge iCLK) begin
    if (state == ST_CLEAR) begin
      mem[cnt] <= '0;
`ifdef DPRAM_SC_PARITY_EN
      par[cnt] <= '0;
`endif
    end else begin
      for (int unsigned k = 0; k < NBE; k++) begin
        if (b_wr && iPB_BE[k]) begin
          mem[iPB_ADDR][k*BEW +: BEW] <= iPB_WDATA[k*BEW +: BEW];
`ifdef DPRAM_SC_PARITY_EN
          par[iPB_ADDR][k] <= ^iPB_WDATA[k*BEW +: BEW];
`endif
        end
      end
      for (int unsigned k = 0; k < NBE; k++) begin
        if (a_wr && iPA_BE[k]) begin
          mem[iPA_ADDR][k*BEW +: BEW] <= iPA_WDATA[k*BEW +: BEW];
`ifdef DPRAM_SC_PARITY_EN
          par[iPA_ADDR][k] <= ^iPA_WDATA[k*BEW +: BEW];
`endif
        end
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) oCOLL <= 1'b0;
    else      oCOLL <= a_wr & b_wr & (iPA_ADDR == iPB_ADDR) & (|(iPA_BE & iPB_BE));
  end

  // ---------------- output stages ----------------
  dpram_sc_rd_pipe #(.DBW(DBW), .OREG(OREG)) u_pipe_a (
    .clk      (iCLK),
    .rst      (iRST),
    .in_valid (a_rd),
    .in_data  (a_rword),
`ifdef DPRAM_SC_PARITY_EN
    .in_perr  (a_perr),
    .perr     (oPA_PERR),
`endif
    .rdata    (oPA_RDATA),
    .rvalid   (oPA_RVALID)
  );

  dpram_sc_rd_pipe #(.DBW(DBW), .OREG(OREG)) u_pipe_b (
    .clk      (iCLK),
    .rst      (iRST),
    .in_valid (b_rd),
    .in_data  (b_rword),
`ifdef DPRAM_SC_PARITY_EN
    .in_perr  (b_perr),
    .perr     (oPB_PERR),
`endif
    .rdata    (oPB_RDATA),
    .rvalid   (oPB_RVALID)
  );

endmodule

// File: tb/tb_dpram_sc_be_clr.sv
`timescale 1ns/1ps
module tb_dpram_sc_be_clr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, clr;
  logic [3:0]  pa_addr, pb_addr, pa_be, pb_be;
  logic        pa_rd, pa_wr, pb_rd, pb_wr;
  logic [31:0] pa_wd, pb_wd;

  // instance 0: OREG=0 write-first, 1: OREG=0 read-first, 2: OREG=1 write-first
  logic [31:0] a_rdata [3];
  logic [31:0] b_rdata [3];
  logic        a_rv [3];
  logic        b_rv [3];
  logic        coll [3];
  logic        ready [3];
`ifdef DPRAM_SC_PARITY_EN
  logic        a_pe [3];
  logic        b_pe [3];
`endif

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    dpram_sc_be_clr #(
      .DBW(32), .DEPTH(16), .BEW(8),
      .OREG((gi == 2) ? 1 : 0), .RDW_MODE((gi == 1) ? 1 : 0)
    ) u_dut (
      .iCLK(clk), .iRST(rst), .iCLR(clr), .oREADY(ready[gi]),
      .iPA_ADDR(pa_addr), .iPA_RD(pa_rd), .iPA_WR(pa_wr), .iPA_BE(pa_be), .iPA_WDATA(pa_wd),
      .oPA_RDATA(a_rdata[gi]), .oPA_RVALID(a_rv[gi]),
      .iPB_ADDR(pb_addr), .iPB_RD(pb_rd), .iPB_WR(pb_wr), .iPB_BE(pb_be), .iPB_WDATA(pb_wd),
      .oPB_RDATA(b_rdata[gi]), .oPB_RVALID(b_rv[gi]),
`ifdef DPRAM_SC_PARITY_EN
      .oPA_PERR(a_pe[gi]), .oPB_PERR(b_pe[gi]),
`endif
      .oCOLL(coll[gi])
    );
  end

  int checks = 0;
  int failures = 0;

  // scoreboard: {perr, data} expected per instance and port
  logic [32:0] qa [3][$];
  logic [32:0] qb [3][$];
  logic [31:0] model [16];
  logic        bad_par [16];
  logic        acc;

  function automatic void chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
    logic [31:0] m;
    m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (old & ~m) | (nw & m);
  endfunction

  function automatic logic [32:0] exp_rd(input logic wf, input logic [31:0] old, input logic pe,
                                         input logic wr, input logic [3:0] be, input logic [31:0] wd);
    if (wr && wf) return {pe & ~be[0], merge(old, wd, be)};
    return {pe, old};
  endfunction

  task automatic cyc(input logic ard, input logic awr, input logic [3:0] aa, input logic [3:0] abe, input logic [31:0] awd,
                     input logic brd, input logic bwr, input logic [3:0] ba, input logic [3:0] bbe, input logic [31:0] bwd);
    logic ecoll;
    pa_rd = ard; pa_wr = awr; pa_addr = aa; pa_be = abe; pa_wd = awd;
    pb_rd = brd; pb_wr = bwr; pb_addr = ba; pb_be = bbe; pb_wd = bwd;
    if (acc) begin
      for (int i = 0; i < 3; i++) begin
        if (ard) qa[i].push_back(exp_rd(i != 1, model[aa], bad_par[aa], awr, abe, awd));
        if (brd) qb[i].push_back(exp_rd(i != 1, model[ba], bad_par[ba], bwr, bbe, bwd));
      end
    end
    ecoll = acc && awr && bwr && (aa == ba) && ((abe & bbe) != 4'd0);
    @(posedge clk); #1;
    if (acc) begin
      if (bwr) begin model[ba] = merge(model[ba], bwd, bbe); if (bbe[0]) bad_par[ba] = 1'b0; end
      if (awr) begin model[aa] = merge(model[aa], awd, abe); if (abe[0]) bad_par[aa] = 1'b0; end
      if (clr) begin
        acc = 1'b0;
        for (int i = 0; i < 16; i++) begin model[i] = '0; bad_par[i] = 1'b0; end
      end
    end
    for (int i = 0; i < 3; i++) chk($sformatf("coll%0d", i), coll[i], ecoll);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  always @(negedge clk) begin : mon
    logic [32:0] e, o;
    for (int i = 0; i < 3; i++) begin
      if (a_rv[i] === 1'b1) begin
        chk($sformatf("a%0d_expected_read", i), qa[i].size() != 0, 1);
        if (qa[i].size() != 0) begin
          e = qa[i].pop_front();
`ifdef DPRAM_SC_PARITY_EN
          o = {a_pe[i], a_rdata[i]};
`else
          o = {1'b0, a_rdata[i]}; e[32] = 1'b0;
`endif
          chk($sformatf("a%0d_rdata", i), o, e);
        end
      end
      if (b_rv[i] === 1'b1) begin
        chk($sformatf("b%0d_expected_read", i), qb[i].size() != 0, 1);
        if (qb[i].size() != 0) begin
          e = qb[i].pop_front();
`ifdef DPRAM_SC_PARITY_EN
          o = {b_pe[i], b_rdata[i]};
`else
          o = {1'b0, b_rdata[i]}; e[32] = 1'b0;
`endif
          chk($sformatf("b%0d_rdata", i), o, e);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; clr = 1'b0; acc = 1'b0;
    pa_rd = 0; pa_wr = 0; pa_addr = 0; pa_be = 0; pa_wd = 0;
    pb_rd = 0; pb_wr = 0; pb_addr = 0; pb_be = 0; pb_wd = 0;
    for (int i = 0; i < 16; i++) begin model[i] = '0; bad_par[i] = 1'b0; end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_a_rdata%0d", i), a_rdata[i], 0);
      chk($sformatf("rst_b_rdata%0d", i), b_rdata[i], 0);
      chk($sformatf("rst_a_rv%0d", i), a_rv[i], 0);
      chk($sformatf("rst_b_rv%0d", i), b_rv[i], 0);
      chk($sformatf("rst_coll%0d", i), coll[i], 0);
      chk($sformatf("rst_ready%0d", i), ready[i], 0);
    end

    // clear after reset: ready low for cycles 0..15, high from 16
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < 3; i++) chk($sformatf("ready%0d_c%0d", i, k), ready[i], k >= 16);
      @(posedge clk); #1;
    end
    acc = 1'b1;

    for (int a = 0; a < 16; a++) cyc(1, 0, 4'(a), 0, 0, 1, 0, 4'(15 - a), 0, 0);

    // byte-enable merge
    cyc(0, 1, 3, 4'b1111, 32'h11223344, 0, 0, 0, 0, 0);
    cyc(0, 1, 3, 4'b0101, 32'hAABBCCDD, 0, 0, 0, 0, 0);
    cyc(0, 1, 3, 4'b0000, 32'hFFFFFFFF, 1, 0, 3, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0, 3, 0, 0);

    // read-during-write, same port and cross port
    cyc(1, 1, 5, 4'b1111, 32'hCAFEF00D, 1, 0, 5, 0, 0);
    cyc(1, 1, 6, 4'b0110, 32'h12345678, 0, 0, 0, 0, 0);
    cyc(1, 0, 5, 0, 0, 1, 0, 6, 0, 0);

    // dual write to one address, overlapping and disjoint lanes
    cyc(0, 1, 7, 4'b0011, 32'hAAAAAAAA, 0, 1, 7, 4'b0110, 32'hBBBBBBBB);
    cyc(1, 0, 7, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 7, 4'b0011, 32'hAAAAAAAA, 0, 1, 7, 4'b1100, 32'hBBBBBBBB);
    cyc(0, 0, 0, 0, 0, 1, 0, 7, 0, 0);
    repeat (3) idle();

    // back-to-back reads: latency 1 on OREG=0, 2 on OREG=1
    for (int k = 0; k < 8; k++) begin
      cyc(k < 4, 0, 4'(k), 0, 0, 0, 0, 0, 0, 0);
      chk($sformatf("lat1_rv_c%0d", k + 1), a_rv[0], (k + 1 >= 1) && (k + 1 <= 4));
      chk($sformatf("lat2_rv_c%0d", k + 1), a_rv[2], (k + 1 >= 2) && (k + 1 <= 5));
    end

    // clear request mid-stream; traffic during clear must be ignored
    for (int k = 0; k < 6; k++) begin
      clr = (k == 2);
      cyc(1, 0, 4'(k), 0, 0, 0, 1, 4'(k + 8), 4'b1111, 32'hFFFFFFFF);
      clr = 1'b0;
      if (k >= 2) chk($sformatf("clr_ready_j%0d", k - 2), ready[0], 0);
    end
    for (int j = 4; j <= 16; j++) begin
      cyc(1, 1, 4'(j), 4'b1111, 32'h5A5A5A5A, 1, 0, 4'(j + 1), 0, 0);
      chk($sformatf("clr_ready_j%0d", j), ready[0], j == 16);
      chk($sformatf("clr_ready2_j%0d", j), ready[2], j == 16);
    end
    acc = 1'b1;
    for (int a = 0; a < 16; a++) cyc(1, 0, 4'(a), 0, 0, 1, 0, 4'(a ^ 5), 0, 0);

`ifdef DPRAM_SC_PARITY_EN
    g_dut[0].u_dut.mem[9][0] = ~g_dut[0].u_dut.mem[9][0];
    g_dut[1].u_dut.mem[9][0] = ~g_dut[1].u_dut.mem[9][0];
    g_dut[2].u_dut.mem[9][0] = ~g_dut[2].u_dut.mem[9][0];
    model[9][0] = ~model[9][0];
    bad_par[9] = 1'b1;
    cyc(1, 0, 9, 0, 0, 1, 0, 8, 0, 0);
    cyc(1, 0, 10, 0, 0, 1, 0, 9, 0, 0);
`endif

    repeat (6) idle();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("a%0d_pending", i), qa[i].size(), 0);
      chk($sformatf("b%0d_pending", i), qb[i].size(), 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dpram_sc_be_clr.md
Name: dpram_sc_be_clr

Overview:
- Single-clock true dual-port RAM. Next generation of the team's parametrised DPRAM.
- Adds per-byte write enables, explicit read strobes with read-valid, and a selectable read-during-write mode.
- Adds an optional output pipeline register and a collision flag.
- Adds a hardware clear engine that zeroes the whole array after reset or on request.
- Sits between DMA/host-side logic and accelerator datapaths as a shared scratch buffer.

Parameters:
- DBW, 32: data width in bits; must be a multiple of BEW.
- DEPTH, 1023: number of words.
- BEW, 8: bits per byte-enable lane. NBE = DBW/BEW lanes.
- OREG, 0: 0 = read latency 1 cycle; 1 = read latency 2 cycles (extra output register).
- RDW_MODE, 0: same-port read-during-write. 0 = write-first (merged new word); 1 = read-first (old word).

Ports:
- iCLK  in  1  clock
- iRST  in  1  synchronous active-high reset
- iCLR  in  1  pulse; requests a full array clear
- oREADY  out  1  high when the clear engine is idle and the ports are serviced
- iPA_ADDR  in  ABW  port A word address (ABW = bit_fit(DEPTH) from bit_fit.vh)
- iPA_RD  in  1  port A read strobe
- iPA_WR  in  1  port A write strobe
- iPA_BE  in  NBE  port A byte enables
- iPA_WDATA  in  DBW  port A write data
- oPA_RDATA  out  DBW  port A read data
- oPA_RVALID  out  1  port A read data valid
- iPB_ADDR / iPB_RD / iPB_WR / iPB_BE / iPB_WDATA / oPB_RDATA / oPB_RVALID: port B, identical to port A
- oCOLL  out  1  one-cycle pulse: both ports wrote overlapping lanes of the same address

Behaviour:
- Reset and outputs:
  - One clock. Reset is synchronous and active-high.
  - On iRST: oPA/oPB_RDATA=0, oPA/oPB_RVALID=0, oCOLL=0, oREADY=0, FSM->CLEAR, clear counter=0, pipeline registers flushed.
- Clear FSM, states CLEAR and RUN:
  - CLEAR: writes 0 to ram[cnt] each cycle and increments cnt. At cnt==DEPTH-1 the FSM enters RUN next cycle.
  - Clear takes exactly DEPTH cycles. oREADY rises on the DEPTH-th cycle after iRST deasserts.
  - RUN: oREADY=1. iCLR=1 -> CLEAR with cnt=0; oREADY drops the next cycle.
  - iCLR during CLEAR is ignored (no restart). iRST during CLEAR restarts the clear.
  - During CLEAR, port RD/WR are ignored: no writes, no RVALID.
- Reads:
  - A read is accepted when RD=1 in RUN.
  - RDATA/RVALID appear after 1 cycle (OREG=0) or 2 cycles (OREG=1). RVALID is high for exactly one cycle per accepted read.
  - RDATA holds its last value when RVALID=0.
  - Back-to-back reads are sustained at one per cycle per port.
- Writes:
  - Accepted when WR=1 in RUN. Only lanes with BE[k]=1 are updated. BE=0 with WR=1 is a no-op.
- Same port, RD and WR in the same cycle:
  - RDW_MODE=0: returns the merged word (new bytes in enabled lanes, old elsewhere).
  - RDW_MODE=1: returns the pre-write word.
- Cross-port, one port writes an address the other reads in the same cycle: the reader always gets the pre-write word.
- Both ports write the same address in the same cycle:
  - Lanes enabled only on A take A; lanes enabled only on B take B; overlapping lanes take A.
  - oCOLL=1 on the following cycle only if at least one lane overlaps.
- Address >= DEPTH (DEPTH not a power of 2): write dropped; read returns 0 with RVALID=1.

Optional Feature:
- Macro DPRAM_SC_PARITY_EN.
- Defined:
  - Array stores one even-parity bit per lane, computed on write.
  - Clear writes a consistent parity of 0.
  - Adds outputs oPA_PERR and oPB_PERR, each 1 bit. PERR is aligned with RVALID and high if any lane of the read word mismatches parity.
  - Reset value of PERR is 0.
- Undefined: no parity storage and no PERR ports. Behaviour is otherwise identical.

Decomposition:
- Shared package/include holds:
  - bit_fit (existing bit_fit.vh);
  - FSM state encodings ST_CLEAR=1'b0 and ST_RUN=1'b1;
  - RDW_WRITE_FIRST=0 and RDW_READ_FIRST=1 constants.
- One sub-module, dpram_sc_rd_pipe: per-port RDATA/RVALID/PERR output stage parametrised by OREG. Instantiated twice.
- Array, clear engine and collision merge stay in the top module.

Test Plan (DBW=32, DEPTH=16, BEW=8):
- Reset release, hold iRST low 20 cycles -> oREADY=0 for cycles 0..15, 1 from cycle 16; every address reads 0x00000000 with RVALID after 1 cycle (OREG=0).
- A writes 0x11223344 @3 with BE=4'b1111, then BE=4'b0101 data 0xAABBCCDD @3; B reads @3 -> 0x11BB33DD.
- RDW_MODE=0 vs 1: A RD+WR @5 (old 0x0, new 0xCAFEF00D, BE=1111) -> oPA_RDATA 0xCAFEF00D vs 0x00000000; B read @5 same cycle -> 0x00000000 in both modes.
- Same-cycle writes @7: A=0xAAAAAAAA BE=0011, B=0xBBBBBBBB BE=0110 -> word 0x00BBAAAA, oCOLL pulses 1 cycle; with B BE=1100 -> 0xBBBBAAAA, oCOLL stays 0.
- OREG=1: 4 back-to-back reads @0..3 -> RVALID high cycles 2..5 with matching data; iCLR mid-stream -> no RVALID for reads issued after CLEAR entry, oREADY back 16 cycles later, all data 0.
- DPRAM_SC_PARITY_EN: force-flip one stored bit via hierarchical poke @9 -> read @9 gives PERR=1 with RVALID; clean addresses give PERR=0.
